// File: rtl/peecc_pkg.sv
// Shared definitions for the PEECC statistics monitor: run-state encoding,
// coded bus width helper and popcount result width.
package peecc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Coded bus width: data bits plus redundancy bits.
  function automatic int coded_width(input int k, input int m);
    return k + m;
  endfunction

  // Bits needed to hold a popcount of a WIDTH-bit vector (0..WIDTH).
  function automatic int pc_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/peecc_stats_monitor_if.sv
// Bus between the PEECC top level (master) and the statistics monitor (slave).
// Optional macro PEECC_COUPLING_EN adds the CouplingCount result.
interface peecc_stats_monitor_if #(
  parameter int k     = 16,
  parameter int M     = 5,
  parameter int CNT_W = 32
);
  localparam int W = k + M;

  logic             Start;
  logic             ValidIn;
  logic [W-1:0]     CodeWord;
  logic             IsEqual;
  logic             Busy;
  logic             Done;
  logic [CNT_W-1:0] WordCount;
  logic [CNT_W-1:0] ErrorCount;
  logic [CNT_W-1:0] TransitionCount;
  logic [CNT_W-1:0] FirstErrIdx;
  logic             FirstErrValid;
`ifdef PEECC_COUPLING_EN
  logic [CNT_W-1:0] CouplingCount;
`endif

  modport master (
    output Start, ValidIn, CodeWord, IsEqual,
`ifdef PEECC_COUPLING_EN
    input  CouplingCount,
`endif
    input  Busy, Done, WordCount, ErrorCount, TransitionCount,
           FirstErrIdx, FirstErrValid
  );

  modport slave (
    input  Start, ValidIn, CodeWord, IsEqual,
`ifdef PEECC_COUPLING_EN
    output CouplingCount,
`endif
    output Busy, Done, WordCount, ErrorCount, TransitionCount,
           FirstErrIdx, FirstErrValid
  );

endinterface

// File: rtl/peecc_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module peecc_popcount
  import peecc_pkg::*;
#(
  parameter int WIDTH = 21
) (
  input  logic [WIDTH-1:0]               vec_i,
  output logic [pc_width(WIDTH)-1:0]     count_o
);
  localparam int CW = pc_width(WIDTH);

  // Sum the set bits of the input vector.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_o = count_o + CW'(vec_i[i]);
    end
  end

endmodule

// File: rtl/peecc_stats_monitor.sv
// Per-run statistics for the PEECC channel: word count, decode-mismatch
// count, bus transition count and first failing word index. All counters
// saturate. Optional macro PEECC_COUPLING_EN adds an opposite-toggle
// (crosstalk) count on adjacent bus lines.
module peecc_stats_monitor
  import peecc_pkg::*;
#(
  parameter int k         = 16,
  parameter int M         = 5,
  parameter int CNT_W     = 32,
  parameter int NUM_WORDS = 1024
) (
  input  logic                   CLK,
  input  logic                   RST,
  peecc_stats_monitor_if.slave   bus
);
  localparam int W   = coded_width(k, M);
  localparam int PCW = pc_width(W);
  localparam int SW  = ((CNT_W > PCW) ? CNT_W : PCW) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   NW_X    = (CNT_W + 1)'(NUM_WORDS);

  // Saturating add of a popcount-sized increment to a counter.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PCW-1:0]   b);
    logic [SW-1:0] sum;
    sum = SW'(a) + SW'(b);
    return (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wc_q, wc_d, ec_q, ec_d, tc_q, tc_d, fei_q, fei_d;
  logic             fev_q, fev_d, prev_valid_q, prev_valid_d;
  logic [W-1:0]     prev_q, prev_d;
  logic             busy, done, start_take, accept, last_word;
  logic [PCW-1:0]   trans_pc;

  assign start_take = bus.Start && (state_q != RUN);
  assign accept     = (state_q == RUN) && bus.ValidIn;
  // End of run uses the unsaturated next word count.
  assign last_word  = accept && (NUM_WORDS != 0) &&
                      (({1'b0, wc_q} + (CNT_W + 1)'(1)) == NW_X);

  peecc_popcount #(.WIDTH(W)) u_pc_trans (
    .vec_i   (bus.CodeWord ^ prev_q),
    .count_o (trans_pc)
  );

`ifdef PEECC_COUPLING_EN
  localparam int CPW = pc_width(W - 1);
  logic [W-1:0]     rise, fall;
  logic [W-2:0]     opp;
  logic [CPW-1:0]   coup_pc;
  logic [CNT_W-1:0] cc_q, cc_d;

  assign rise = bus.CodeWord & ~prev_q;
  assign fall = ~bus.CodeWord & prev_q;
  // Pair (i, i+1) toggles in opposite directions.
  assign opp  = (rise[W-2:0] & fall[W-1:1]) | (fall[W-2:0] & rise[W-1:1]);

  peecc_popcount #(.WIDTH(W - 1)) u_pc_coup (
    .vec_i   (opp),
    .count_o (coup_pc)
  );

  assign bus.CouplingCount = cc_q;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: Start is only honoured outside RUN.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.Start) state_d = RUN;
      RUN:     if (last_word) state_d = DONE;
      DONE:    if (bus.Start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from state.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Next values of the statistics registers.
  always_comb begin
    wc_d         = wc_q;
    ec_d         = ec_q;
    tc_d         = tc_q;
    fei_d        = fei_q;
    fev_d        = fev_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
`ifdef PEECC_COUPLING_EN
    cc_d         = cc_q;
`endif
    if (start_take) begin
      wc_d         = '0;
      ec_d         = '0;
      tc_d         = '0;
      fei_d        = '0;
      fev_d        = 1'b0;
      prev_valid_d = 1'b0;
`ifdef PEECC_COUPLING_EN
      cc_d         = '0;
`endif
    end else if (accept) begin
      wc_d = sat_add(wc_q, PCW'(1));
      if (!bus.IsEqual) begin
        ec_d = sat_add(ec_q, PCW'(1));
        if (!fev_q) begin
          fei_d = wc_q;
          fev_d = 1'b1;
        end
      end
      if (prev_valid_q) begin
        tc_d = sat_add(tc_q, trans_pc);
`ifdef PEECC_COUPLING_EN
        cc_d = sat_add(cc_q, PCW'(coup_pc));
`endif
      end
      prev_d       = bus.CodeWord;
      prev_valid_d = 1'b1;
    end
  end

  // Statistics registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wc_q         <= '0;
      ec_q         <= '0;
      tc_q         <= '0;
      fei_q        <= '0;
      fev_q        <= 1'b0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
`ifdef PEECC_COUPLING_EN
      cc_q         <= '0;
`endif
    end else begin
      wc_q         <= wc_d;
      ec_q         <= ec_d;
      tc_q         <= tc_d;
      fei_q        <= fei_d;
      fev_q        <= fev_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
`ifdef PEECC_COUPLING_EN
      cc_q         <= cc_d;
`endif
    end
  end

  assign bus.Busy            = busy;
  assign bus.Done            = done;
  assign bus.WordCount       = wc_q;
  assign bus.ErrorCount      = ec_q;
  assign bus.TransitionCount = tc_q;
  assign bus.FirstErrIdx     = fei_q;
  assign bus.FirstErrValid   = fev_q;

endmodule

// File: tb/tb_peecc_stats_monitor.sv
// Bench for peecc_stats_monitor. Four instances cover the run lengths and
// counter widths of interest: d0 (NUM_WORDS=4), d1 (NUM_WORDS=8),
// d2 (CNT_W=4, unbounded), d3 (NUM_WORDS=2). A history-based model derives
// every output from the list of accepted words of the current run.
module tb_peecc_stats_monitor;

  localparam int ND = 4;
  localparam int HL = 32;

  logic CLK;
  logic RST;

  logic        start_v [ND];
  logic        valid_v [ND];
  logic        eq_v    [ND];
  logic [20:0] cw_v    [ND];

  logic [31:0] wc_a [ND], ec_a [ND], tc_a [ND], fei_a [ND];
  logic        busy_a [ND], done_a [ND], fev_a [ND];
`ifdef PEECC_COUPLING_EN
  logic [31:0] cc_a [ND];
`endif

  int nw      [ND] = '{4, 8, 0, 2};
  int cnt_bits[ND] = '{32, 32, 4, 32};

  int n_checks = 0;
  int n_errors = 0;

  peecc_stats_monitor_if #(.k(16), .M(5), .CNT_W(32)) if0 ();
  peecc_stats_monitor_if #(.k(16), .M(5), .CNT_W(32)) if1 ();
  peecc_stats_monitor_if #(.k(16), .M(5), .CNT_W(4))  if2 ();
  peecc_stats_monitor_if #(.k(16), .M(5), .CNT_W(32)) if3 ();

  peecc_stats_monitor #(.k(16), .M(5), .CNT_W(32), .NUM_WORDS(4))
    dut0 (.CLK(CLK), .RST(RST), .bus(if0));
  peecc_stats_monitor #(.k(16), .M(5), .CNT_W(32), .NUM_WORDS(8))
    dut1 (.CLK(CLK), .RST(RST), .bus(if1));
  peecc_stats_monitor #(.k(16), .M(5), .CNT_W(4), .NUM_WORDS(0))
    dut2 (.CLK(CLK), .RST(RST), .bus(if2));
  peecc_stats_monitor #(.k(16), .M(5), .CNT_W(32), .NUM_WORDS(2))
    dut3 (.CLK(CLK), .RST(RST), .bus(if3));

  assign if0.Start = start_v[0]; assign if0.ValidIn = valid_v[0];
  assign if0.CodeWord = cw_v[0]; assign if0.IsEqual = eq_v[0];
  assign if1.Start = start_v[1]; assign if1.ValidIn = valid_v[1];
  assign if1.CodeWord = cw_v[1]; assign if1.IsEqual = eq_v[1];
  assign if2.Start = start_v[2]; assign if2.ValidIn = valid_v[2];
  assign if2.CodeWord = cw_v[2]; assign if2.IsEqual = eq_v[2];
  assign if3.Start = start_v[3]; assign if3.ValidIn = valid_v[3];
  assign if3.CodeWord = cw_v[3]; assign if3.IsEqual = eq_v[3];

  assign wc_a[0] = if0.WordCount;  assign ec_a[0] = if0.ErrorCount;
  assign tc_a[0] = if0.TransitionCount; assign fei_a[0] = if0.FirstErrIdx;
  assign busy_a[0] = if0.Busy; assign done_a[0] = if0.Done; assign fev_a[0] = if0.FirstErrValid;
  assign wc_a[1] = if1.WordCount;  assign ec_a[1] = if1.ErrorCount;
  assign tc_a[1] = if1.TransitionCount; assign fei_a[1] = if1.FirstErrIdx;
  assign busy_a[1] = if1.Busy; assign done_a[1] = if1.Done; assign fev_a[1] = if1.FirstErrValid;
  assign wc_a[2] = 32'(if2.WordCount);  assign ec_a[2] = 32'(if2.ErrorCount);
  assign tc_a[2] = 32'(if2.TransitionCount); assign fei_a[2] = 32'(if2.FirstErrIdx);
  assign busy_a[2] = if2.Busy; assign done_a[2] = if2.Done; assign fev_a[2] = if2.FirstErrValid;
  assign wc_a[3] = if3.WordCount;  assign ec_a[3] = if3.ErrorCount;
  assign tc_a[3] = if3.TransitionCount; assign fei_a[3] = if3.FirstErrIdx;
  assign busy_a[3] = if3.Busy; assign done_a[3] = if3.Done; assign fev_a[3] = if3.FirstErrValid;
`ifdef PEECC_COUPLING_EN
  assign cc_a[0] = if0.CouplingCount;
  assign cc_a[1] = if1.CouplingCount;
  assign cc_a[2] = 32'(if2.CouplingCount);
  assign cc_a[3] = if3.CouplingCount;
`endif

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- model: run state plus history of accepted words -------
  int          m_state [ND];   // 0 idle, 1 running, 2 finished
  int          m_len   [ND];
  logic [20:0] m_word  [ND][HL];
  bit          m_err   [ND][HL];

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int d = 0; d < ND; d++) begin
        m_state[d] <= 0;
        m_len[d]   <= 0;
      end
    end else begin
      for (int d = 0; d < ND; d++) begin
        if (m_state[d] != 1) begin
          if (start_v[d]) begin
            m_state[d] <= 1;
            m_len[d]   <= 0;
          end
        end else if (valid_v[d]) begin
          if (m_len[d] < HL) begin
            m_word[d][m_len[d]] <= cw_v[d];
            m_err[d][m_len[d]]  <= !eq_v[d];
          end
          m_len[d] <= m_len[d] + 1;
          if (nw[d] != 0 && m_len[d] + 1 == nw[d]) m_state[d] <= 2;
        end
      end
    end
  end

  function automatic longint satv(input int d, input longint v);
    longint mx;
    mx = (64'd1 << cnt_bits[d]) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic int hlen(input int d);
    return (m_len[d] < HL) ? m_len[d] : HL;
  endfunction

  function automatic longint exp_ec(input int d);
    longint s = 0;
    for (int i = 0; i < hlen(d); i++) if (m_err[d][i]) s++;
    return satv(d, s);
  endfunction

  function automatic longint exp_tc(input int d);
    longint s = 0;
    for (int i = 1; i < hlen(d); i++) s += $countones(m_word[d][i] ^ m_word[d][i-1]);
    return satv(d, s);
  endfunction

  function automatic longint exp_first(input int d, output bit found);
    found = 1'b0;
    for (int i = 0; i < hlen(d); i++) begin
      if (m_err[d][i]) begin
        found = 1'b1;
        return satv(d, i);
      end
    end
    return 0;
  endfunction

  // Opposite toggles: both lines of a pair toggle while they started at
  // different levels, so one rose and the other fell.
  function automatic longint exp_cc(input int d);
    longint s = 0;
    logic [20:0] a, b;
    for (int i = 1; i < hlen(d); i++) begin
      a = m_word[d][i-1];
      b = m_word[d][i];
      for (int j = 0; j < 20; j++)
        if (a[j] != b[j] && a[j+1] != b[j+1] && a[j] != a[j+1]) s++;
    end
    return satv(d, s);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- per-cycle comparison against the model ----------------
  bit chk_en = 1'b0;
  always begin
    @(posedge CLK);
    #1;
    if (chk_en) begin
      for (int d = 0; d < ND; d++) begin
        bit     fv;
        longint fi;
        fi = exp_first(d, fv);
        check($sformatf("d%0d.WordCount", d),       wc_a[d],   satv(d, m_len[d]));
        check($sformatf("d%0d.ErrorCount", d),      ec_a[d],   exp_ec(d));
        check($sformatf("d%0d.TransitionCount", d), tc_a[d],   exp_tc(d));
        check($sformatf("d%0d.FirstErrIdx", d),     fei_a[d],  fi);
        check($sformatf("d%0d.FirstErrValid", d),   fev_a[d],  fv);
        check($sformatf("d%0d.Busy", d),            busy_a[d], (m_state[d] == 1) ? 1 : 0);
        check($sformatf("d%0d.Done", d),            done_a[d], (m_state[d] == 2) ? 1 : 0);
`ifdef PEECC_COUPLING_EN
        check($sformatf("d%0d.CouplingCount", d),   cc_a[d],   exp_cc(d));
`endif
      end
    end
  end

  // One stimulus cycle for instance d, applied at the falling edge.
  task automatic cyc(input int d, input bit s, input bit v, input logic [20:0] w, input bit e);
    @(negedge CLK);
    start_v[d] = s;
    valid_v[d] = v;
    cw_v[d]    = w;
    eq_v[d]    = e;
  endtask

  task automatic idle(input int d);
    cyc(d, 1'b0, 1'b0, 21'h0, 1'b1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    RST = 1'b0;
    for (int d = 0; d < ND; d++) begin
      start_v[d] = 1'b0; valid_v[d] = 1'b0; cw_v[d] = '0; eq_v[d] = 1'b1;
    end
    chk_en = 1'b1;

    // Reset held with ValidIn toggling: nothing may move.
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      for (int d = 0; d < ND; d++) begin
        valid_v[d] = ~valid_v[d];
        cw_v[d]    = 21'h1FFFFF;
      end
    end
    @(negedge CLK);
    check("rst.busy0", busy_a[0], 0);
    check("rst.wc1",   wc_a[1],   0);
    for (int d = 0; d < ND; d++) valid_v[d] = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    check("rst.idle_busy0", busy_a[0], 0);
    check("rst.idle_done0", done_a[0], 0);

    // Activity run, four words.
    cyc(0, 1, 0, 21'h0, 1);
    cyc(0, 0, 1, 21'h000000, 1);
    cyc(0, 0, 1, 21'h1FFFFF, 1);
    cyc(0, 0, 1, 21'h1FFFFF, 1);
    cyc(0, 0, 1, 21'h000000, 1);
    idle(0);
    check("act.wc",   wc_a[0], 4);
    check("act.tc",   tc_a[0], 42);
    check("act.ec",   ec_a[0], 0);
    check("act.fev",  fev_a[0], 0);
    check("act.done", done_a[0], 1);
    check("act.busy", busy_a[0], 0);
    cyc(0, 0, 1, 21'h0ABCDE, 0);
    cyc(0, 0, 1, 21'h154321, 0);
    idle(0);
    check("act.wc_after_done", wc_a[0], 4);
    check("act.ec_after_done", ec_a[0], 0);

    // Error run, eight words, mismatches at indices 2 and 5.
    cyc(1, 1, 0, 21'h0, 1);
    for (int i = 0; i < 8; i++)
      cyc(1, 0, 1, 21'(i * 32'h012345), (i == 2 || i == 5) ? 1'b0 : 1'b1);
    idle(1);
    check("err.ec",   ec_a[1], 2);
    check("err.fei",  fei_a[1], 2);
    check("err.fev",  fev_a[1], 1);
    check("err.wc",   wc_a[1], 8);
    check("err.done", done_a[1], 1);
    // Restart from DONE.
    cyc(1, 1, 0, 21'h0, 1);
    idle(1);
    check("restart.wc",   wc_a[1], 0);
    check("restart.ec",   ec_a[1], 0);
    check("restart.tc",   tc_a[1], 0);
    check("restart.fev",  fev_a[1], 0);
    check("restart.busy", busy_a[1], 1);

    // Saturation on the 4-bit instance: 20 mismatching alternating words.
    cyc(2, 1, 0, 21'h0, 1);
    for (int i = 0; i < 20; i++) cyc(2, 0, 1, (i % 2 == 0) ? 21'h0 : 21'h1, 0);
    idle(2);
    check("sat.wc",   wc_a[2], 15);
    check("sat.ec",   ec_a[2], 15);
    check("sat.tc",   tc_a[2], 15);
    check("sat.busy", busy_a[2], 1);
    check("sat.fei",  fei_a[2], 0);

    // Two-word run for adjacent-line coupling.
    cyc(3, 1, 0, 21'h0, 1);
    cyc(3, 0, 1, 21'h000001, 1);
    cyc(3, 0, 1, 21'h000002, 1);
    idle(3);
    check("cpl.tc",   tc_a[3], 2);
    check("cpl.done", done_a[3], 1);
`ifdef PEECC_COUPLING_EN
    check("cpl.cc",   cc_a[3], 1);
`endif

    // Reset in the middle of a run on d1 (already running after restart).
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 21'(32'h0F0F0F >> i), 1);
    idle(1);
    check("midrst.wc_before", wc_a[1], 3);
    #2;
    RST = 1'b0;
    #1;
    check("midrst.wc",   wc_a[1], 0);
    check("midrst.busy", busy_a[1], 0);
    check("midrst.sat_wc", wc_a[2], 0);
    @(negedge CLK);
    RST = 1'b1;
    cyc(1, 1, 0, 21'h0, 1);
    cyc(1, 0, 1, 21'h000123, 1);
    idle(1);
    check("midrst.restart_wc", wc_a[1], 1);
    check("midrst.restart_busy", busy_a[1], 1);

    repeat (2) @(negedge CLK);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/peecc_stats_monitor.md
Name: peecc_stats_monitor

Overview:
Downstream statistics stage for the PEECC encode/decode top level. It consumes the per-word valid strobe, the transmitted coded bus word and the decoder IsEqual verdict. Per measurement run it accumulates:
- word count
- decode-mismatch count
- bus switching activity (transition count)
- index of the first failing word

Software/bench reads the results after Done. It is the measurement point for the power and reliability figures of the coding scheme.

Parameters:
k, 16, data word width feeding the encoder
M, 5, redundancy bits added by the encoder; coded bus width W = k+M
CNT_W, 32, width of every statistics counter
NUM_WORDS, 1024, words per run; 0 = unbounded run (never reaches DONE)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous active-low reset
Start  input  1  one-cycle pulse: clear counters, begin a run
ValidIn  input  1  CodeWord/IsEqual valid this cycle
CodeWord  input  k+M  coded bus word as driven on the channel
IsEqual  input  1  decoder output matched source data for this word
Busy  output  1  run in progress
Done  output  1  run complete, results stable
WordCount  output  CNT_W  valid words accepted this run
ErrorCount  output  CNT_W  accepted words with IsEqual=0
TransitionCount  output  CNT_W  sum of popcount(CodeWord XOR previous accepted CodeWord)
FirstErrIdx  output  CNT_W  zero-based index of first mismatching word
FirstErrValid  output  1  FirstErrIdx holds a captured value

Behaviour:
- Reset (RST=0, asynchronous): state IDLE; all outputs 0; prev-word register 0; PrevValid 0.
- States:
  - IDLE: Start -> RUN.
  - RUN: Busy=1; accept words.
  - DONE: Done=1, Busy=0; Start -> RUN.
  - Start in RUN is ignored; the run is not restarted.
- Start taken in IDLE or DONE, same edge: zero all counters, FirstErrValid and PrevValid.
- Accept condition: state RUN and ValidIn=1. ValidIn in IDLE/DONE is ignored; no backpressure.
- On each accept, all outputs update on the next rising edge (latency 1):
  - WordCount += 1.
  - ErrorCount += 1 if IsEqual=0.
  - If IsEqual=0 and FirstErrValid=0: FirstErrIdx := current WordCount (pre-increment); FirstErrValid := 1.
  - If PrevValid=1: TransitionCount += popcount(CodeWord ^ prev). The first word of a run adds nothing.
  - prev := CodeWord; PrevValid := 1.
- Popcount result width is $clog2(W+1) and is zero-extended to CNT_W before the add.
- All counters saturate at 2^CNT_W-1; no wrap. With NUM_WORDS != 0, the NUM_WORDS check uses the unsaturated comparison.
- Run end: the edge that makes WordCount == NUM_WORDS (NUM_WORDS != 0) also moves the state to DONE. Done asserts in the same cycle WordCount shows the final value.
- NUM_WORDS=0: stays in RUN until reset.
- Reset mid-run: immediate return to IDLE, all results lost.

Optional Feature:
PEECC_COUPLING_EN
- Defined:
  - Adds output CouplingCount [CNT_W-1:0], reset 0, cleared on Start, saturating.
  - For each accept with PrevValid=1, adds the number of adjacent bit pairs (i, i+1), i=0..W-2, that toggle in opposite directions (one 0->1, the other 1->0). This is the crosstalk-dominant coupling metric.
  - Same latency and timing as TransitionCount.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package peecc_pkg:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - coded-width helper W = k+M
  - popcount-width constant function
- One sub-module, peecc_popcount (parameter WIDTH, combinational). It is instantiated once for transitions and once more under PEECC_COUPLING_EN for the opposite-toggle vector.
- Saturating increment is a local function, not a module.

Test Plan:
- Reset: hold RST=0 for 3 cycles, toggle ValidIn. All outputs stay 0 and Busy=0. Release RST; still IDLE.
- Activity (NUM_WORDS=4): Start, then words 0x000000, 0x1FFFFF, 0x1FFFFF, 0x000000, all IsEqual=1. Expect WordCount=4, TransitionCount=42, ErrorCount=0, FirstErrValid=0. Done=1 on the edge after the 4th word; extra ValidIn afterwards ignored.
- Errors (NUM_WORDS=8): IsEqual=0 on word indices 2 and 5. Expect ErrorCount=2, FirstErrIdx=2, FirstErrValid=1. Restart via Start in DONE: all counters 0 one cycle later.
- Saturation (CNT_W=4, NUM_WORDS=0): 20 mismatching words alternating 0x000000/0x000001. Expect WordCount=15, ErrorCount=15, TransitionCount=15, Busy remains 1.
- Reset mid-run: RST=0 after 3 of 8 words. Async clear to IDLE with 0 outputs before the next edge. A new Start restarts from WordCount=0.
- Coupling (macro defined, NUM_WORDS=2): words 0x000001 then 0x000002. Expect CouplingCount=1, TransitionCount=2. With macro undefined, TransitionCount=2 and the port is absent.
